vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter FB_AW, default 15, shall set the framebuffer address width.
REQ-002 Parameter FB_DEPTH, default 19200, shall set the number of valid framebuffer words (160x120 RGB332).
REQ-003 Port list, one per line:
- clk  in  1  system clock (100 MHz); one pixel spans 4 clocks.
- rst_n  in  1  reset; asynchronous, active-low.
- disp_req  in  1  scan-out needs a pixel (active area).
- disp_addr  in  FB_AW  scan-out pixel address.
- pix  out  8  registered RGB332 pixel to the sync block.
- wr_req  in  1  game-logic write request.
- wr_addr  in  FB_AW  write address.
- wr_data  in  8  write data.
- wr_ack  out  1  write accepted this cycle.
- wr_err  out  1  accepted write was out of range (pulse).
- clr_start  in  1  start full-framebuffer fill (pulse).
- clr_color  in  8  fill colour.
- busy  out  1  fill in progress.
- clr_done  out  1  fill finished (pulse).
- mem_addr  out  FB_AW  single-port RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data; synchronous read, 1-cycle latency.

Function
REQ-004 A free-running 2-bit slot counter shall advance 0,1,2,3,0 every clock.
REQ-005 In slot 0 with disp_req=1, the display shall own the port: mem_addr=disp_addr, mem_we=0.
REQ-006 pix shall load mem_rdata on the clock edge that ends slot 1 when a display read was issued in the preceding slot 0; pix shall load 0 at that edge when no display read was issued (blanking).
REQ-007 Every other cycle shall be a writer slot: slots 1-3, and slot 0 with disp_req=0.
REQ-008 State machine states shall be IDLE and CLEAR only.
REQ-009 In IDLE, a writer slot with wr_req=1 shall assert wr_ack combinationally for that cycle, drive mem_addr=wr_addr and mem_wdata=wr_data, and assert mem_we=1 iff wr_addr<FB_DEPTH.
REQ-010 An accepted write with wr_addr>=FB_DEPTH shall keep mem_we=0 and pulse wr_err with wr_ack.
REQ-011 The writer shall hold wr_req, wr_addr and wr_data stable until wr_ack; wr_ack shall never assert outside a writer slot.
REQ-012 In IDLE, clr_start=1 shall latch clr_color, clear the fill counter to 0 and enter CLEAR on the next edge; that cycle shall still serve wr_req normally.
REQ-013 In CLEAR, busy=1, wr_ack=0, and every writer slot shall write the latched colour at the fill counter address (mem_we=1); the counter shall then increment.
REQ-014 The write at address FB_DEPTH-1 shall end CLEAR: return to IDLE on that edge and pulse clr_done for exactly the following cycle.
REQ-015 clr_start in CLEAR shall be ignored; clr_color changes during CLEAR shall have no effect.
REQ-016 When neither display nor writer owns the cycle, mem_we=0 and mem_addr/mem_wdata shall hold their previous value.
REQ-017 Display reads shall never be delayed or dropped by writer or fill traffic.

Reset
REQ-018 While rst_n=0, the block shall hold slot=0, state=IDLE, fill counter=0, pix=0, busy=0, clr_done=0, wr_ack=0, wr_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-019 Reset asserted mid-fill shall abort CLEAR without a clr_done pulse; after release the block shall start at slot 0 in IDLE.

Verification
REQ-020 disp_req=1, disp_addr=5, RAM[5]=0xE3 -> mem_addr=5 in slot 0; pix=0xE3 from slot 2, held until the next slot 2.
REQ-021 wr_req=1, wr_addr=10, wr_data=0x1C held through slot 0 with disp_req=1 -> no ack in slot 0; wr_ack and mem_we in slot 1; RAM[10]=0x1C.
REQ-022 wr_req=1, wr_addr=19200 -> wr_ack=1, wr_err=1, mem_we=0; RAM unchanged.
REQ-023 clr_start with clr_color=0x03, disp_req=0 -> busy for 19200 cycles; clr_done pulses once; all RAM words=0x03; wr_req unacked until IDLE.
REQ-024 clr_start with disp_req=1 continuously -> fill takes 25600 cycles; pix still updates every 4 clocks.
REQ-025 rst_n low at fill counter=100 -> all outputs at reset values; no clr_done; wr_req acked in the first writer slot after release.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: a fixed 4-clock slot wheel gives scan-out one
// read per pixel in slot 0; every remaining cycle goes to game writes or a full-screen fill.
module vga_fb_arbiter #(
  parameter int unsigned FB_AW    = 15,
  parameter int unsigned FB_DEPTH = 19200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_req,
  input  logic [FB_AW-1:0] disp_addr,
  output logic [7:0]       pix,
  input  logic             wr_req,
  input  logic [FB_AW-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  output logic             wr_ack,
  output logic             wr_err,
  input  logic             clr_start,
  input  logic [7:0]       clr_color,
  output logic             busy,
  output logic             clr_done,
  output logic [FB_AW-1:0] mem_addr,
  output logic             mem_we,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [FB_AW:0]   DEPTH_EXT = (FB_AW+1)'(FB_DEPTH);
  localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(FB_DEPTH - 1);

  state_t           state, state_nxt;
  logic [1:0]       slot;
  logic [FB_AW-1:0] fill_cnt;
  logic [FB_AW-1:0] addr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       clr_color_q;
  logic             disp_rd_q;

  logic disp_slot_c, writer_slot_c, in_range_c, fill_last_c;

  assign disp_slot_c   = (slot == 2'd0) && disp_req;
  assign writer_slot_c = !disp_slot_c;
  assign in_range_c    = {1'b0, wr_addr} < DEPTH_EXT;
  assign fill_last_c   = (state == CLEAR) && writer_slot_c && (fill_cnt == LAST_ADDR);
  assign busy          = (state == CLEAR);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start)   state_nxt = CLEAR;
      CLEAR:   if (fill_last_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Port ownership; an unowned cycle replays the last address/data so the RAM pins stay quiet
  always_comb begin
    wr_ack    = 1'b0;
    wr_err    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (rst_n) begin
      if (disp_slot_c) begin
        mem_addr = disp_addr;
      end else begin
        case (state)
          IDLE: begin
            if (wr_req) begin
              wr_ack    = 1'b1;
              wr_err    = !in_range_c;
              mem_we    = in_range_c;
              mem_addr  = wr_addr;
              mem_wdata = wr_data;
            end
          end
          CLEAR: begin
            mem_we    = 1'b1;
            mem_addr  = fill_cnt;
            mem_wdata = clr_color_q;
          end
          default: ;
        endcase
      end
    end
  end

  // Slot wheel, pixel capture, fill counter and bus hold registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot        <= 2'd0;
      fill_cnt    <= '0;
      clr_color_q <= 8'h00;
      disp_rd_q   <= 1'b0;
      pix         <= 8'h00;
      clr_done    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
    end else begin
      slot     <= slot + 2'd1;
      addr_q   <= mem_addr;
      wdata_q  <= mem_wdata;
      clr_done <= fill_last_c;
      if (slot == 2'd0) disp_rd_q <= disp_req;
      // Read data arrives in slot 1; a skipped read blanks the pixel
      if (slot == 2'd1) pix <= disp_rd_q ? mem_rdata : 8'h00;
      if (state == IDLE && clr_start) begin
        fill_cnt    <= '0;
        clr_color_q <= clr_color;
      end else if (state == CLEAR && writer_slot_c) begin
        fill_cnt <= fill_cnt + FB_AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter with a behavioural RAM and an address->data
// scoreboard; slot ownership is predicted from the cycle count since reset.
module tb_vga_fb_arbiter;

  localparam int unsigned FB_AW     = 15;
  localparam int unsigned FB_DEPTH  = 19200;
  localparam int unsigned RAM_WORDS = 1 << FB_AW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             disp_req = 1'b0;
  logic [FB_AW-1:0] disp_addr = '0;
  logic [7:0]       pix;
  logic             wr_req = 1'b0;
  logic [FB_AW-1:0] wr_addr = '0;
  logic [7:0]       wr_data = 8'h00;
  logic             wr_ack, wr_err;
  logic             clr_start = 1'b0;
  logic [7:0]       clr_color = 8'h00;
  logic             busy, clr_done;
  logic [FB_AW-1:0] mem_addr;
  logic             mem_we;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  logic [7:0]       ram [0:RAM_WORDS-1];
  logic             pre_we = 1'b0;
  logic [FB_AW-1:0] pre_addr = '0;
  logic [7:0]       pre_data = 8'h00;
  logic [7:0]       exp_mem [int];
  logic [1:0]       tb_slot;

  vga_fb_arbiter #(.FB_AW(FB_AW), .FB_DEPTH(FB_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .pix(pix),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .clr_start(clr_start), .clr_color(clr_color), .busy(busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous single-port RAM plus a bench-side preload port
  always @(posedge clk) begin
    if (mem_we)      ram[mem_addr] <= mem_wdata;
    else if (pre_we) ram[pre_addr] <= pre_data;
    mem_rdata <= ram[mem_addr];
  end

  // Cycle position since reset release, modulo the 4-clock pixel period
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_slot <= 2'd0;
    else        tb_slot <= tb_slot + 2'd1;
  end

  always @(negedge clk) if (clr_done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_slot(input logic [1:0] s);
    for (int i = 0; i < 4 && tb_slot != s; i++) step();
  endtask

  task automatic preload(input logic [FB_AW-1:0] a, input logic [7:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    step();
    pre_we = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    logic [31:0] got;
    got = {pix, busy, clr_done, wr_ack, wr_err, mem_we, mem_wdata, 7'(0), mem_addr[7:0]};
    n_cmp++;
    if (pix !== 8'h00 || busy !== 1'b0 || clr_done !== 1'b0 || wr_ack !== 1'b0 ||
        wr_err !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 8'h00) begin
      n_err++;
      $display("FAIL %s: outputs pix/busy/done/ack/err/we/wdata/addr=%h mem_addr=%h, required all zero",
               tag, got, mem_addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    disp_req = 1'b1; disp_addr = FB_AW'(123); wr_req = 1'b1; wr_addr = FB_AW'(9);
    wr_data = 8'hA5; clr_start = 1'b1; clr_color = 8'h77;
    #2;
    check_outputs_zero("reset_async");
    repeat (3) step();
    check_outputs_zero("reset_held");
    disp_req = 1'b0; wr_req = 1'b0; clr_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (tb_slot !== 2'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_release: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_display();
    logic [FB_AW-1:0] a;
    logic [7:0] d;
    logic r;
    preload(FB_AW'(5), 8'hE3);
    goto_slot(2'd0);
    disp_req = 1'b1; disp_addr = FB_AW'(5);
    #1;
    n_cmp++;
    if (mem_addr !== FB_AW'(5) || mem_we !== 1'b0) begin
      n_err++; $display("FAIL disp_slot0: mem_addr=%0d we=%b, required 5 0", mem_addr, mem_we);
    end
    step(); disp_req = 1'b0;
    step();
    n_cmp++;
    if (pix !== 8'hE3) begin n_err++; $display("FAIL disp_pix_slot2: pix=%h, required e3", pix); end
    step(); step(); step();
    n_cmp++;
    if (pix !== 8'hE3) begin n_err++; $display("FAIL disp_pix_hold: pix=%h, required e3", pix); end
    step();
    n_cmp++;
    if (pix !== 8'h00) begin n_err++; $display("FAIL disp_blank: pix=%h, required 00", pix); end
    for (int n = 0; n < 16; n++) begin
      a = FB_AW'($urandom_range(0, FB_DEPTH - 1));
      d = 8'($urandom);
      r = 1'($urandom);
      preload(a, d);
      goto_slot(2'd0);
      disp_req = r; disp_addr = a;
      #1;
      n_cmp++;
      if (mem_we !== 1'b0 || (r && mem_addr !== a)) begin
        n_err++; $display("FAIL disp_rand_addr: mem_addr=%0d we=%b, required %0d 0", mem_addr, mem_we, a);
      end
      step(); disp_req = 1'b0;
      step();
      n_cmp++;
      if (pix !== (r ? d : 8'h00)) begin
        n_err++; $display("FAIL disp_rand_pix: pix=%h, required %h", pix, r ? d : 8'h00);
      end
    end
  endtask

  task automatic test_write_directed();
    goto_slot(2'd0);
    disp_req = 1'b1; disp_addr = FB_AW'(0);
    wr_req = 1'b1; wr_addr = FB_AW'(10); wr_data = 8'h1C;
    #1;
    n_cmp++;
    if (wr_ack !== 1'b0 || mem_we !== 1'b0) begin
      n_err++; $display("FAIL wr_blocked_slot0: ack=%b we=%b, required 0 0", wr_ack, mem_we);
    end
    step(); disp_req = 1'b0;
    #1;
    n_cmp++;
    if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== FB_AW'(10) || mem_wdata !== 8'h1C) begin
      n_err++; $display("FAIL wr_slot1: ack=%b we=%b addr=%0d data=%h, required 1 1 10 1c",
                        wr_ack, mem_we, mem_addr, mem_wdata);
    end
    step(); wr_req = 1'b0;
    exp_mem[10] = 8'h1C;
    n_cmp++;
    if (ram[10] !== 8'h1C) begin n_err++; $display("FAIL wr_ram10: ram=%h, required 1c", ram[10]); end
    preload(FB_AW'(FB_DEPTH), 8'hAA);
    wr_req = 1'b1; wr_addr = FB_AW'(FB_DEPTH); wr_data = 8'h55;
    goto_slot(2'd2);
    #1;
    n_cmp++;
    if (wr_ack !== 1'b1 || wr_err !== 1'b1 || mem_we !== 1'b0) begin
      n_err++; $display("FAIL wr_oor: ack=%b err=%b we=%b, required 1 1 0", wr_ack, wr_err, mem_we);
    end
    step(); wr_req = 1'b0;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0 || mem_addr !== FB_AW'(FB_DEPTH) || mem_wdata !== 8'h55 || wr_err !== 1'b0) begin
      n_err++; $display("FAIL bus_hold: we=%b addr=%0d data=%h err=%b, required 0 %0d 55 0",
                        mem_we, mem_addr, mem_wdata, wr_err, FB_DEPTH);
    end
    step();
    n_cmp++;
    if (ram[FB_DEPTH] !== 8'hAA) begin
      n_err++; $display("FAIL wr_oor_ram: ram=%h, required aa", ram[FB_DEPTH]);
    end
  endtask

  task automatic test_write_random();
    logic [FB_AW-1:0] a;
    logic [7:0] d;
    logic inr, acked, exp_w;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) a = FB_AW'(FB_DEPTH + $urandom_range(0, 100));
      else                           a = FB_AW'($urandom_range(0, FB_DEPTH - 1));
      d = 8'($urandom);
      inr = (int'(a) < int'(FB_DEPTH));
      acked = 1'b0;
      for (int c = 0; c < 8 && !acked; c++) begin
        step();
        disp_req = 1'($urandom); disp_addr = FB_AW'($urandom_range(0, FB_DEPTH - 1));
        if (c == 0) begin wr_req = 1'b1; wr_addr = a; wr_data = d; end
        #1;
        exp_w = !(tb_slot == 2'd0 && disp_req);
        n_cmp++;
        if (wr_ack !== exp_w) begin
          n_err++; $display("FAIL wr_rand_ack: slot=%0d disp=%b ack=%b, required %b", tb_slot, disp_req, wr_ack, exp_w);
        end
        if (wr_ack === 1'b1) begin
          acked = 1'b1;
          n_cmp++;
          if (mem_we !== inr || wr_err !== !inr || mem_addr !== a) begin
            n_err++; $display("FAIL wr_rand_bus: we=%b err=%b addr=%0d, required %b %b %0d",
                              mem_we, wr_err, mem_addr, inr, !inr, a);
          end
        end
      end
      n_cmp++;
      if (!acked) begin n_err++; $display("FAIL wr_rand_timeout: ack=0, required 1 within 8 cycles"); end
      if (inr) exp_mem[int'(a)] = d;
    end
    step(); wr_req = 1'b0; disp_req = 1'b0;
    step();
    foreach (exp_mem[k]) begin
      n_cmp++;
      if (ram[FB_AW'(k)] !== exp_mem[k]) begin
        n_err++; $display("FAIL wr_rand_ram[%0d]: ram=%h, required %h", k, ram[FB_AW'(k)], exp_mem[k]);
      end
    end
  endtask

  task automatic check_fill(input string tag, input logic [7:0] col, input int keep_addr,
                            input logic [7:0] keep_data);
    int bad;
    logic [7:0] e;
    bad = 0;
    for (int i = 0; i < int'(FB_DEPTH); i++) begin
      e = (i == keep_addr) ? keep_data : col;
      if (ram[FB_AW'(i)] !== e) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL %s: %0d words differ, required 0", tag, bad); end
  endtask

  task automatic test_clear();
    int cyc, ack_bad, d0;
    disp_req = 1'b0; wr_req = 1'b0;
    step();
    clr_start = 1'b1; clr_color = 8'h03;
    step();
    clr_start = 1'b0;
    wr_req = 1'b1; wr_addr = FB_AW'(7); wr_data = 8'hC5;
    d0 = done_cnt; cyc = 0; ack_bad = 0;
    #1;
    while (busy === 1'b1 && cyc < 30000) begin
      cyc++;
      if (wr_ack !== 1'b0) ack_bad++;
      step();
      if (busy === 1'b1) begin
        clr_start = ($urandom_range(0, 15) == 0);
        clr_color = 8'($urandom);
      end else begin
        clr_start = 1'b0;
      end
      #1;
    end
    n_cmp++;
    if (cyc != int'(FB_DEPTH)) begin n_err++; $display("FAIL clr_len: busy cycles=%0d, required %0d", cyc, FB_DEPTH); end
    n_cmp++;
    if (ack_bad != 0) begin n_err++; $display("FAIL clr_ack: acks during fill=%0d, required 0", ack_bad); end
    n_cmp++;
    if (clr_done !== 1'b1 || wr_ack !== 1'b1 || mem_we !== 1'b1) begin
      n_err++; $display("FAIL clr_end: done=%b ack=%b we=%b, required 1 1 1", clr_done, wr_ack, mem_we);
    end
    step(); wr_req = 1'b0;
    #1;
    n_cmp++;
    if (clr_done !== 1'b0 || done_cnt - d0 != 1) begin
      n_err++; $display("FAIL clr_done_pulse: done=%b pulses=%0d, required 0 1", clr_done, done_cnt - d0);
    end
    step();
    check_fill("clr_ram", 8'h03, 7, 8'hC5);
  endtask

  task automatic test_clear_disp();
    logic [FB_AW-1:0] hi_a [16];
    logic [7:0]       hi_d [16];
    logic [7:0] col, pend;
    logic have;
    int cyc, pix_bad, pix_chk, k, d0;
    for (int i = 0; i < 16; i++) begin
      hi_a[i] = FB_AW'(FB_DEPTH + i * 512 + $urandom_range(0, 511));
      hi_d[i] = 8'($urandom);
      preload(hi_a[i], hi_d[i]);
    end
    col = 8'($urandom);
    goto_slot(2'd3);
    clr_start = 1'b1; clr_color = col; disp_req = 1'b1;
    step();
    clr_start = 1'b0;
    d0 = done_cnt; cyc = 0; pix_bad = 0; pix_chk = 0; have = 1'b0; pend = 8'h00;
    while (busy === 1'b1 && cyc < 40000) begin
      cyc++;
      if (tb_slot == 2'd0) begin
        k = $urandom_range(0, 15);
        disp_addr = hi_a[k]; pend = hi_d[k]; have = 1'b1;
        clr_color = 8'($urandom);
      end else if (tb_slot == 2'd2 && have) begin
        pix_chk++;
        if (pix !== pend) pix_bad++;
      end
      step();
    end
    disp_req = 1'b0;
    n_cmp++;
    if (cyc != 25600) begin n_err++; $display("FAIL clrd_len: busy cycles=%0d, required 25600", cyc); end
    n_cmp++;
    if (pix_bad != 0 || pix_chk < 6000) begin
      n_err++; $display("FAIL clrd_pix: bad=%0d checked=%0d, required 0 and >=6000", pix_bad, pix_chk);
    end
    n_cmp++;
    if (clr_done !== 1'b1) begin n_err++; $display("FAIL clrd_done: done=%b, required 1", clr_done); end
    step(); step();
    n_cmp++;
    if (done_cnt - d0 != 1) begin n_err++; $display("FAIL clrd_pulses: pulses=%0d, required 1", done_cnt - d0); end
    check_fill("clrd_ram", col, -1, 8'h00);
  endtask

  task automatic test_reset_mid_fill();
    int d0;
    logic [FB_AW-1:0] a;
    logic [7:0] d;
    disp_req = 1'b0; wr_req = 1'b0;
    step();
    clr_start = 1'b1; clr_color = 8'($urandom);
    step();
    clr_start = 1'b0;
    repeat (100) step();
    d0 = done_cnt;
    a = FB_AW'($urandom_range(0, FB_DEPTH - 1));
    d = 8'($urandom);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL rstfill_busy: busy=%b, required 1", busy); end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rstfill_async");
    step(); step();
    check_outputs_zero("rstfill_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a || busy !== 1'b0) begin
      n_err++; $display("FAIL rstfill_first_wr: ack=%b we=%b addr=%0d busy=%b, required 1 1 %0d 0",
                        wr_ack, mem_we, mem_addr, busy, a);
    end
    step(); wr_req = 1'b0;
    repeat (8) step();
    n_cmp++;
    if (done_cnt != d0 || busy !== 1'b0 || ram[a] !== d) begin
      n_err++; $display("FAIL rstfill_after: pulses=%0d busy=%b ram=%h, required 0 0 %h",
                        done_cnt - d0, busy, ram[a], d);
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_write_directed();
    test_write_random();
    test_clear();
    test_clear_disp();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
